// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard bus between pipeline stages and the register file
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  localparam int AW = $clog2(DEPTH);
  logic                    ready;
  logic [NWRITE-1:0]       we;
  logic [NWRITE*AW-1:0]    waddr;
  logic [NWRITE*WIDTH-1:0] wdata;
  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*WIDTH-1:0]  rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    bset;
  logic [AW-1:0]           bset_addr;
  modport master (input ready, rdata, rbusy, output we, waddr, wdata, raddr, bset, bset_addr);
  modport slave  (output ready, rdata, rbusy, input we, waddr, wdata, raddr, bset, bset_addr);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, zero register, pending-write scoreboard and init sequencer
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter bit ZERO_REG = 1
) (
  input logic        clk,
  input logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic                 run;
  logic [NREAD*WIDTH-1:0] rdata_d;
  logic [NREAD-1:0]     rbusy_d;
  // state, init counter and scoreboard; array is deliberately left out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
  // leave INIT once the last register has been zeroed
  always_comb begin
    state_d = (state_q == INIT && cnt_q == AW'(DEPTH-1)) ? RUN : state_q;
    cnt_d   = (state_q == INIT) ? cnt_q + AW'(1) : '0;
  end
  // ready and read-side outputs; everything reads as zero until init completes
  always_comb begin
    run     = (state_q == RUN);
    rdata_d = '0;
    rbusy_d = '0;
    if (run) begin
      for (int j = 0; j < NREAD; j++) begin
        rdata_d[j*WIDTH +: WIDTH] = mem_q[bus.raddr[j*AW +: AW]];
        for (int i = 0; i < NWRITE; i++)
          if (bus.we[i] && bus.waddr[i*AW +: AW] == bus.raddr[j*AW +: AW])
            rdata_d[j*WIDTH +: WIDTH] = bus.wdata[i*WIDTH +: WIDTH];
        if (ZERO_REG && bus.raddr[j*AW +: AW] == '0) rdata_d[j*WIDTH +: WIDTH] = '0;
        rbusy_d[j] = busy_q[bus.raddr[j*AW +: AW]];
      end
    end
  end
  assign bus.ready = run;
  assign bus.rdata = rdata_d;
  assign bus.rbusy = rbusy_d;
  // writes clear pending bits, bset applied last so a same-cycle set wins
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int i = 0; i < NWRITE; i++)
        if (bus.we[i]) busy_d[bus.waddr[i*AW +: AW]] = 1'b0;
      if (bus.bset) busy_d[bus.bset_addr] = 1'b1;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end
  // array: zero-fill during INIT, then port writes with the highest index landing last
  always_ff @(posedge clk) begin
    if (!run) mem_q[cnt_q] <= '0;
    else
      for (int i = 0; i < NWRITE; i++)
        if (bus.we[i] && !(ZERO_REG && bus.waddr[i*AW +: AW] == '0))
          mem_q[bus.waddr[i*AW +: AW]] <= bus.wdata[i*WIDTH +: WIDTH];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of init, bypass, port priority, zero register, scoreboard and reset
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  regfile_mp_if bus ();
  regfile_mp dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic bs, input logic [4:0] ba);
    @(negedge clk);
    bus.we = we;
    bus.waddr = {wa1, wa0};
    bus.wdata = {wd1, wd0};
    bus.raddr = {ra1, ra0};
    bus.bset = bs;
    bus.bset_addr = ba;
    #1;
  endtask
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        chk({tag, "_rdata"}, bus.rdata[31:0], 32'h0);
        chk({tag, "_rbusy"}, {30'd0, bus.rbusy}, 32'h0);
      end
    end
    chk({tag, "_cycles"}, n, 32);
    bus.we = '0;
    bus.bset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] acc_d;
    logic [31:0] acc_b;
    bus.we = 2'b11;
    bus.waddr = {5'd6, 5'd4};
    bus.wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bus.raddr = {5'd6, 5'd4};
    bus.bset = 1'b1;
    bus.bset_addr = 5'd4;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'h0);
    chk("rst_rdata", bus.rdata[31:0], 32'h0);
    #1 rst_n = 1'b1;
    wait_ready("init");
    acc_d = '0;
    acc_b = '0;
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(31 - a), 5'(a)};
      #1;
      acc_d = acc_d | bus.rdata[31:0] | bus.rdata[63:32];
      acc_b = acc_b | {30'd0, bus.rbusy};
    end
    chk("init_zero", acc_d, 32'h0);
    chk("init_busy", acc_b, 32'h0);
    drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("bypass_r5", bus.rdata[31:0], 32'hDEAD_BEEF);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    chk("stored_r5", bus.rdata[31:0], 32'hDEAD_BEEF);
    chk("stored_r5_p1", bus.rdata[63:32], 32'hDEAD_BEEF);
    drive(2'b11, 5'd7, 32'h1111_1111, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 1'b0, 5'd0);
    chk("conflict_bypass", bus.rdata[31:0], 32'h2222_2222);
    chk("conflict_bypass_p1", bus.rdata[63:32], 32'h2222_2222);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0);
    chk("conflict_stored", bus.rdata[31:0], 32'h2222_2222);
    drive(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    chk("zero_bypass", bus.rdata[31:0], 32'h0);
    chk("zero_busy_now", {30'd0, bus.rbusy}, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("zero_after", bus.rdata[31:0], 32'h0);
    chk("zero_busy_after", {30'd0, bus.rbusy}, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
    chk("sb_set_same_cycle", {31'd0, bus.rbusy[0]}, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    chk("sb_set_next", {30'd0, bus.rbusy}, 32'h3);
    drive(2'b10, 5'd0, 32'h0, 5'd9, 32'hAAAA_AAAA, 5'd9, 5'd9, 1'b0, 5'd0);
    chk("sb_clr_same_cycle", {31'd0, bus.rbusy[0]}, 32'h1);
    chk("sb_clr_bypass", bus.rdata[31:0], 32'hAAAA_AAAA);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    chk("sb_clr_next", {31'd0, bus.rbusy[0]}, 32'h0);
    drive(2'b01, 5'd9, 32'h5555_5555, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
    chk("sb_both_same_cycle", {31'd0, bus.rbusy[0]}, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    chk("sb_both_busy", {31'd0, bus.rbusy[0]}, 32'h1);
    chk("sb_both_data", bus.rdata[31:0], 32'h5555_5555);
    drive(2'b01, 5'd3, 32'h0000_1234, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
    chk("pre_rst_data", bus.rdata[31:0], 32'h0000_1234);
    chk("pre_rst_busy", {31'd0, bus.rbusy[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'h0);
    chk("mid_rst_busy", {30'd0, bus.rbusy}, 32'h0);
    chk("mid_rst_rdata", bus.rdata[31:0], 32'h0);
    #1 rst_n = 1'b1;
    wait_ready("reinit");
    bus.raddr = {5'd9, 5'd3};
    #1;
    chk("reinit_r3", bus.rdata[31:0], 32'h0);
    chk("reinit_r9", bus.rdata[63:32], 32'h0);
    chk("reinit_busy", {30'd0, bus.rbusy}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the 32x32 2R1W file in the integer pipeline.
- Adds configurable width, depth and read/write port counts, plus write-first bypass on every read port.
- Adds a hardwired zero register option and a per-register pending-write scoreboard for long-latency ops.
- Adds a post-reset init sequencer that zeroes the array, so the array needs no async-reset flops. Sits between decode (reads, busy set) and writeback (writes, busy clear).

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers; power of two, >=2
AW, $clog2(DEPTH), address bits (derived)
NREAD, 2, read ports
NWRITE, 2, write ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ready  out  1  1 = init complete, array usable
we  in  NWRITE  per-port write enable
waddr  in  NWRITE*AW  write addresses, port i at [i*AW +: AW]
wdata  in  NWRITE*WIDTH  write data, port i at [i*WIDTH +: WIDTH]
raddr  in  NREAD*AW  read addresses
rdata  out  NREAD*WIDTH  read data, combinational
rbusy  out  NREAD  scoreboard bit of raddr[i], combinational
bset  in  1  mark register bset_addr pending
bset_addr  in  AW  register to mark pending

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- FSM states: INIT and RUN.
- rst_n low, asynchronously:
  - state = INIT, init counter = 0, ready = 0.
  - All scoreboard bits = 0.
  - Array contents are not reset directly.
- INIT, each cycle:
  - mem[cnt] <= 0 and cnt increments.
  - At cnt == DEPTH-1, the next state is RUN.
  - ready rises on the first RUN cycle, exactly DEPTH cycles after rst_n deasserts.
- During INIT:
  - All we and bset are ignored.
  - rdata = 0 and rbusy = 0 on every port.
- Reset asserted mid-INIT or mid-RUN: immediate return to INIT with cnt = 0. The full DEPTH-cycle sequence restarts.
- RUN writes:
  - On posedge, for each i with we[i]: mem[waddr[i]] <= wdata[i].
  - Same address on several ports in one cycle: the highest port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- RUN reads (combinational, no latency):
  - rdata[j] is 0 if ZERO_REG and raddr[j]==0.
  - Otherwise, if any we[i] targets raddr[j] this cycle, rdata[j] is that wdata[i] (write-first bypass), using the highest matching i.
  - Otherwise rdata[j] = mem[raddr[j]].
- Scoreboard (RUN only):
  - Any write with we[i] clears busy[waddr[i]] on posedge.
  - bset sets busy[bset_addr] on posedge.
  - bset and a write to the same address in the same cycle: set wins, busy = 1 after the edge.
  - ZERO_REG and address 0: the bit is never set.
- rbusy timing:
  - rbusy[j] = busy[raddr[j]] is the registered value, with no bypass.
  - It reflects a clear or set only from the cycle after the edge.
- Widths: addresses >= DEPTH cannot occur, since DEPTH is a power of two. No arithmetic is performed on data.

Test Plan:
- Init sequence: deassert rst_n with DEPTH=32 and drive we=1 throughout INIT. Required: ready stays 0 for exactly 32 cycles then rises. Reading every address afterwards returns 0x00000000, so INIT writes were ignored.
- Write/read and bypass: write 0xDEADBEEF to r5 on port 0. In the same cycle raddr[0]=5 must read 0xDEADBEEF. The next cycle, with we=0, it still reads 0xDEADBEEF.
- Write-port conflict: port0 writes 0x11111111 and port1 writes 0x22222222 to r7 in the same cycle. Required: bypass read gives 0x22222222, and the stored value is 0x22222222.
- Zero register: write 0xFFFFFFFF to r0 together with bset on r0. Required: r0 reads 0, and rbusy stays 0 both in that cycle and afterwards.
- Scoreboard: bset r9, then the next cycle rbusy[r9]=1. A write to r9 makes rbusy 0 only from the following cycle. Simultaneous bset r9 and a write to r9 leave rbusy=1 while the data updates.
- Reset mid-run: set busy on r3 and write r3=0x1234, then pulse rst_n low for a partial cycle. Required: ready=0 immediately and rbusy=0. After 32 cycles ready=1 and r3 reads 0.
